// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU control unit: instruction opcodes,
// controller FSM states (4-bit encodings, visible on state_out) and ALU selects.
package cpu_pkg;

   typedef enum logic [3:0] {
      OpNoop  = 4'd0,
      OpStore = 4'd1,
      OpLoad  = 4'd2,
      OpAdd   = 4'd3,
      OpSub   = 4'd4,
      OpHalt  = 4'd5
   } opcode_t;

   typedef enum logic [3:0] {
      StInit   = 4'd0,
      StFetch  = 4'd1,
      StDecode = 4'd2,
      StNoop   = 4'd3,
      StStore  = 4'd4,
      StLoadA  = 4'd5,
      StLoadB  = 4'd6,
      StAdd    = 4'd7,
      StSub    = 4'd8,
      StHalt   = 4'd9
   } ctrl_state_t;

   localparam logic [2:0] ALU_PASS_A = 3'b000;
   localparam logic [2:0] ALU_ADD    = 3'b001;
   localparam logic [2:0] ALU_SUB    = 3'b010;

   // Execute state entered from DECODE; opcodes 6-15 fall back to NOOP.
   function automatic ctrl_state_t exec_state(logic [3:0] opcode);
      ctrl_state_t st;
      case (opcode_t'(opcode))
         OpStore: st = StStore;
         OpLoad:  st = StLoadA;
         OpAdd:   st = StAdd;
         OpSub:   st = StSub;
         OpHalt:  st = StHalt;
         default: st = StNoop;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/instr_fetch_regs.sv
// Program counter and instruction register with load/increment controls.
// Synchronous active-low reset clears both; PC wraps silently at 2^PC_W.
module instr_fetch_regs #(
   parameter int unsigned PC_W = 7
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ir_load,
   input  logic            pc_inc,
   input  logic [15:0]     ir_in,
   output logic [PC_W-1:0] pc,
   output logic [15:0]     ir
);

   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     ir_q, ir_d;

   // Next-state for PC and IR from the load/increment controls.
   always_comb begin
      pc_d = pc_q;
      ir_d = ir_q;
      if (pc_inc) begin
         pc_d = pc_q + PC_W'(1);
      end
      if (ir_load) begin
         ir_d = ir_in;
      end
   end

   // PC/IR registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q <= '0;
         ir_q <= '0;
      end else begin
         pc_q <= pc_d;
         ir_q <= ir_d;
      end
   end

   assign pc = pc_q;
   assign ir = ir_q;

endmodule

// File: rtl/cpu_controller.sv
// CPU control unit: Moore FSM that fetches 16-bit instructions and drives the
// register-file, ALU and data-memory controls of the datapath.
// Optional feature macro CPU_CTRL_SINGLE_STEP_EN adds a `step` input that holds
// the FSM in FETCH until step=1 is sampled.
module cpu_controller
   import cpu_pkg::*;
#(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned PC_W   = 7
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef CPU_CTRL_SINGLE_STEP_EN
   input  logic              step,
`endif
   input  logic [15:0]       IR_data,
   output logic [PC_W-1:0]   PC_addr,
   output logic [7:0]        D_addr,
   output logic              D_wr,
   output logic              RF_s,
   output logic              RF_W_en,
   output logic [REG_AW-1:0] RF_W_addr,
   output logic [REG_AW-1:0] RF_Ra_addr,
   output logic [REG_AW-1:0] RF_Rb_addr,
   output logic [2:0]        ALU_s0,
   output logic [3:0]        state_out,
   output logic              halted
);

   ctrl_state_t state_q, state_d;
   logic        ir_load;
   logic        pc_inc;
   logic        fetch_go;
   logic [15:0] ir;

   logic [REG_AW-1:0] field_a, field_b, field_c;

`ifdef CPU_CTRL_SINGLE_STEP_EN
   assign fetch_go = step;
`else
   assign fetch_go = 1'b1;
`endif

   assign field_a = REG_AW'(ir[11:8]);
   assign field_b = REG_AW'(ir[7:4]);
   assign field_c = REG_AW'(ir[3:0]);

   instr_fetch_regs #(
      .PC_W (PC_W)
   ) u_fetch_regs (
      .clk     (clk),
      .rst_n   (rst_n),
      .ir_load (ir_load),
      .pc_inc  (pc_inc),
      .ir_in   (IR_data),
      .pc      (PC_addr),
      .ir      (ir)
   );

   // State register; reset wins from any state, including mid-LOAD.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StInit;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state sequencing and fetch controls.
   always_comb begin
      state_d = state_q;
      ir_load = 1'b0;
      pc_inc  = 1'b0;
      case (state_q)
         StInit:   state_d = StFetch;
         StFetch: begin
            if (fetch_go) begin
               ir_load = 1'b1;
               pc_inc  = 1'b1;
               state_d = StDecode;
            end
         end
         StDecode: state_d = exec_state(ir[15:12]);
         StLoadA:  state_d = StLoadB;
         StNoop, StStore, StLoadB, StAdd, StSub: state_d = StFetch;
         StHalt:   state_d = StHalt;
         default:  state_d = StInit;
      endcase
   end

   // Moore output decode from state and IR only; everything idles at zero.
   always_comb begin
      D_addr     = '0;
      D_wr       = 1'b0;
      RF_s       = 1'b0;
      RF_W_en    = 1'b0;
      RF_W_addr  = '0;
      RF_Ra_addr = '0;
      RF_Rb_addr = '0;
      ALU_s0     = ALU_PASS_A;
      case (state_q)
         StStore: begin
            D_addr     = ir[7:0];
            RF_Ra_addr = field_a;
            D_wr       = 1'b1;
         end
         StLoadA, StLoadB: begin
            D_addr    = ir[7:0];
            RF_s      = 1'b1;
            RF_W_addr = field_a;
            // Write only in the second cycle, once memory data has settled.
            RF_W_en   = (state_q == StLoadB);
         end
         StAdd, StSub: begin
            RF_Ra_addr = field_a;
            RF_Rb_addr = field_b;
            RF_W_addr  = field_c;
            ALU_s0     = (state_q == StAdd) ? ALU_ADD : ALU_SUB;
            RF_W_en    = 1'b1;
         end
         default: ;
      endcase
   end

   assign state_out = state_q;
   assign halted    = (state_q == StHalt);

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Control unit that drives the CPU datapath (register file, ALU, data memory) from a 16-bit instruction stream. It sits on the initiator side of the datapath control interface, which otherwise has to be driven by a testbench. It owns the program counter and instruction register and fetches from instruction memory. A Moore FSM sequences each instruction and produces the register-file write/read addresses, write enable, ALU select, data-memory address and write strobe.

## Interface
- `REG_AW`, 5: register-file address width; 4-bit instruction fields are zero-extended to this width.
- `PC_W`, 7: program counter / instruction-memory address width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; one clock, synchronous, active-low.
- `IR_data`  in  16  instruction-memory read data; combinational from `PC_addr`.
- `PC_addr`  out  PC_W  instruction-memory address (current PC).
- `D_addr`  out  8  data-memory address.
- `D_wr`  out  1  data-memory write strobe.
- `RF_s`  out  1  RF write-data mux select: 1 = memory data, 0 = ALU result.
- `RF_W_en`  out  1  register-file write enable.
- `RF_W_addr`  out  REG_AW  register-file write address.
- `RF_Ra_addr`, `RF_Rb_addr`  out  REG_AW  register-file read addresses.
- `ALU_s0`  out  3  ALU operation select.
- `state_out`  out  4  current FSM state encoding (debug).
- `halted`  out  1  high while in HALT.

## Operation
- Instruction format: opcode `IR[15:12]`, field A `IR[11:8]`, field B `IR[7:4]`, field C `IR[3:0]`.
- Opcodes:
  - 0 NOOP.
  - 1 STORE: `M[IR[7:0]] <= R[A]`.
  - 2 LOAD: `R[A] <= M[IR[7:0]]`.
  - 3 ADD: `R[C] <= R[A] + R[B]`.
  - 4 SUB: `R[C] <= R[A] - R[B]`.
  - 5 HALT.
  - 6–15 are illegal and execute as NOOP.
- ALU_s0 codes: PASS_A = 000, ADD = 001, SUB = 010.
- FSM states:
  - INIT → FETCH.
  - FETCH: IR ← `IR_data`; PC ← PC+1. → DECODE.
  - DECODE → the opcode's execute state.
  - NOOP → FETCH.
  - STORE: `D_addr`=`IR[7:0]`, `RF_Ra_addr`=A, `D_wr`=1. → FETCH.
  - LOAD_A: `D_addr`=`IR[7:0]`, `RF_s`=1, `RF_W_addr`=A. → LOAD_B.
  - LOAD_B: same as LOAD_A, plus `RF_W_en`=1. → FETCH.
  - ADD / SUB: `RF_Ra_addr`=A, `RF_Rb_addr`=B, `RF_W_addr`=C, `ALU_s0`=ADD/SUB, `RF_W_en`=1. → FETCH.
  - HALT: self-loop until reset.
- Outputs are decoded combinationally from the state register and IR only. No input-to-output path exists except through `PC_addr`.
- Every strobe (`D_wr`, `RF_W_en`) is 0 and every address/select output is 0 in INIT, FETCH, DECODE, NOOP and HALT.
- PC wraps from 2^PC_W−1 to 0 with no flag.
- `halted` = (state == HALT).

## Timing
- Reset: `rst_n` low at a rising edge forces state=INIT, PC=0, IR=0, from any state including mid-LOAD.
- All outputs are 0 while in INIT.
- First FETCH occurs in the cycle after INIT.
- Cycles per instruction, FETCH through last execute cycle:
  - NOOP/STORE/ADD/SUB/illegal: 3.
  - LOAD: 4.
  - HALT: enters HALT on cycle 3 and stays.
- `PC_addr` changes one cycle after FETCH, i.e. during DECODE.
- An RF write or memory write occurs on the rising edge that ends its execute state. Exactly one write pulse is issued per instruction.

## Configuration
- `CPU_CTRL_SINGLE_STEP_EN`:
  - Defined: adds input port `step` (1 bit). FSM holds in FETCH, with IR and PC unchanged and all strobes 0, until `step`=1 is sampled at a rising edge; then it performs the fetch and proceeds normally. `step` held high runs at full speed.
  - Undefined: no `step` port; FETCH always completes in one cycle.

## Structure
- Package `cpu_pkg`:
  - opcode enum `opcode_t`.
  - state enum `ctrl_state_t` (4-bit encodings, exported on `state_out`).
  - ALU select constants `ALU_PASS_A`, `ALU_ADD`, `ALU_SUB`.
- Sub-module `instr_fetch_regs`: PC and IR registers with load/increment controls and synchronous active-low reset.
- FSM and output decode live in `cpu_controller`.

## Test plan
- Reset held 2 cycles, then released → `state_out`=INIT for one cycle, then FETCH; `PC_addr`=0; all strobes 0.
- `IR_data`=16'h3127 (ADD) → in execute cycle: `RF_Ra_addr`=1, `RF_Rb_addr`=2, `RF_W_addr`=7, `ALU_s0`=001, `RF_W_en`=1 for exactly 1 cycle; next FETCH at PC=1.
- `IR_data`=16'h2A1F (LOAD) → LOAD_A then LOAD_B with `D_addr`=8'h1F, `RF_s`=1, `RF_W_addr`=10; `RF_W_en` high only in LOAD_B; 4 cycles total.
- STORE 16'h1380 then HALT 16'h5000 → `D_wr`=1 for one cycle with `D_addr`=8'h80 and `RF_Ra_addr`=3; then `halted`=1 indefinitely and PC frozen at 2.
- Illegal opcode 16'hF123 → NOOP timing, no strobes. Also: reset asserted during LOAD_A → INIT next cycle, no `RF_W_en` pulse.
- With `CPU_CTRL_SINGLE_STEP_EN`: `step`=0 for 5 cycles → FSM remains in FETCH with PC unchanged; a 1-cycle `step` pulse → exactly one instruction executes.
